// File: rtl/systolic_ctrl_3by3.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_3by3
//
// Sequencer for a 3x3 systolic array. It holds two 3x3 8-bit operand
// matrices (A and B) loaded through a simple write port. On start it clears
// the array for one cycle, streams the operands into the array edges with
// the diagonal skew a systolic array expects, samples the array output a
// fixed number of cycles after the first feed cycle, and presents that
// sample through a valid/ready handshake.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   synchronous, active-high reset
//   w_en/w_sel/w_row/w_col  operand write (sel 0 = A, 1 = B), IDLE only;
//   w_data                  a row or column index of 3 drops the write
//   start                   run request, IDLE only
//   busy                    high whenever the sequencer is not IDLE
//   arr_clr                 one-cycle clear pulse to the array
//   in_a_0..2               skewed A operands (row i on in_a_i)
//   in_b_0..2               skewed B operands (column j on in_b_j)
//   arr_out                 array result input
//   res_data/res_valid      captured result and its valid flag
//   res_ready               consumer accepts the result
//
// All outputs come straight from flops. Their next values are derived from
// the next state, so each output already matches the state it belongs to
// in the first cycle of that state.
// ---------------------------------------------------------------------------
module systolic_ctrl_3by3 #(
    // Cycles from the first FEED cycle to the cycle in which arr_out is
    // sampled. Legal range 5..15; the cycle counter is 4 bits wide.
    parameter int unsigned CAPTURE_LAT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_en,
    input  logic       w_sel,
    input  logic [1:0] w_row,
    input  logic [1:0] w_col,
    input  logic [7:0] w_data,
    input  logic       start,
    output logic       busy,
    output logic       arr_clr,
    output logic [7:0] in_a_0,
    output logic [7:0] in_a_1,
    output logic [7:0] in_a_2,
    output logic [7:0] in_b_0,
    output logic [7:0] in_b_1,
    output logic [7:0] in_b_2,
    input  logic [7:0] arr_out,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    // The last feed step is t=4: the far corner element needs two cycles of
    // skew on top of the two cycles it takes to walk a 3-wide edge.
    localparam logic [3:0] FEED_LAST = 4'd4;
    localparam logic [3:0] CAP_CNT   = 4'(CAPTURE_LAT);

    // State and cycle counter. During FEED the counter is the skew time t.
    // It then keeps counting through DRAIN so the capture point is measured
    // from the first FEED cycle.
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Operand storage, indexed [row][col].
    logic [2:0][2:0][7:0] a_q, a_d;
    logic [2:0][2:0][7:0] b_q, b_d;

    // Registered outputs.
    logic            busy_q, busy_d;
    logic            arr_clr_q, arr_clr_d;
    logic [2:0][7:0] in_a_q, in_a_d;
    logic [2:0][7:0] in_b_q, in_b_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;

    logic write_ok;

    // Writes are accepted only in IDLE. An index of 3 is out of range, so
    // the write is dropped instead of landing on an aliased location.
    assign write_ok = (state_q == S_IDLE) && w_en &&
                      (w_row != 2'd3) && (w_col != 2'd3);

    // Next state, counter, operand storage and result capture.
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no
        // path through the case leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;

        if (write_ok) begin
            if (w_sel) begin
                b_d[w_row][w_col] = w_data;
            end else begin
                a_d[w_row][w_col] = w_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = 4'd0;
            end
            S_FEED: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CAP_CNT) begin
                    res_data_d = arr_out;
                    state_d    = S_RESULT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESULT: begin
                // The handshake completes in the cycle res_ready is seen.
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skewed feed values for the next cycle. Row i of A enters on in_a_i
    // delayed by i cycles, so A[i][k] appears at t = i + k; column j of B
    // enters on in_b_j the same way, so B[k][j] appears at t = j + k.
    // Storage is read from a_q/b_q: a write taken together with start has
    // already landed by the time the CLEAR cycle computes the t=0 values.
    always_comb begin
        in_a_d = '0;
        in_b_d = '0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (cnt_d == 4'(i + k)) begin
                        in_a_d[i] = a_q[i][k];
                        in_b_d[i] = b_q[k][i];
                    end
                end
            end
        end
    end

    // Status outputs follow the next state so they line up with it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        arr_clr_d   = (state_d == S_CLEAR);
        res_valid_d = (state_d == S_RESULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand storage is part of the reset domain; a run
            // started straight after reset must feed zeros, so the 18 bytes
            // are cleared along with the control state.
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            arr_clr_q   <= 1'b0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            res_data_q  <= 8'd0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the values from before this edge.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            arr_clr_q   <= arr_clr_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = busy_q;
    assign arr_clr   = arr_clr_q;
    assign in_a_0    = in_a_q[0];
    assign in_a_1    = in_a_q[1];
    assign in_a_2    = in_a_q[2];
    assign in_b_0    = in_b_q[0];
    assign in_b_1    = in_b_q[1];
    assign in_b_2    = in_b_q[2];
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_systolic_ctrl_3by3.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl_3by3
//
// Self-checking bench for systolic_ctrl_3by3 with the default CAPTURE_LAT=7.
// arr_out is driven with the running cycle index, so a captured value tells
// exactly which cycle was sampled. Inputs change 1 time unit after a rising
// edge and outputs are read at the same point, well away from the edge.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl_3by3;

    logic       clk;
    logic       reset;
    logic       w_en;
    logic       w_sel;
    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [7:0] w_data;
    logic       start;
    logic       busy;
    logic       arr_clr;
    logic [7:0] in_a_0, in_a_1, in_a_2;
    logic [7:0] in_b_0, in_b_1, in_b_2;
    logic [7:0] arr_out;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;

    systolic_ctrl_3by3 #(.CAPTURE_LAT(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .w_en      (w_en),
        .w_sel     (w_sel),
        .w_row     (w_row),
        .w_col     (w_col),
        .w_data    (w_data),
        .start     (start),
        .busy      (busy),
        .arr_clr   (arr_clr),
        .in_a_0    (in_a_0),
        .in_a_1    (in_a_1),
        .in_a_2    (in_a_2),
        .in_b_0    (in_b_0),
        .in_b_1    (in_b_1),
        .in_b_2    (in_b_2),
        .arr_out   (arr_out),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs for that cycle and the outputs expected
    // in it. cap marks the cycle whose res_data must hold the sample taken
    // at offset 9 from start.
    typedef struct {
        logic       start;
        logic       ready;
        logic       busy;
        logic       clr;
        logic [7:0] a0, a1, a2;
        logic [7:0] b0, b1, b2;
        logic       valid;
        logic       cap;
    } vec_t;

    vec_t tbl [12];

    int cyc;
    int checks;
    int errors;
    int n0;
    int nw;
    logic [7:0] held;

    function automatic vec_t mk(input logic st, input logic rd, input logic bz,
                                input logic cl,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input logic v, input logic cp);
        vec_t r;
        r.start = st; r.ready = rd; r.busy = bz; r.clr = cl;
        r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.b0 = b0; r.b1 = b1; r.b2 = b2;
        r.valid = v; r.cap = cp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic check_feeds(input string tag,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
        check({tag, "_a"}, {8'd0, in_a_2, in_a_1, in_a_0}, {8'd0, a2, a1, a0});
        check({tag, "_b"}, {8'd0, in_b_2, in_b_1, in_b_0}, {8'd0, b2, b1, b0});
    endtask

    // Advance one cycle; arr_out carries the new cycle index.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        arr_out = 8'(cyc);
    endtask

    task automatic write_op(input logic sel, input logic [1:0] row,
                            input logic [1:0] col, input logic [7:0] data);
        w_en = 1'b1; w_sel = sel; w_row = row; w_col = col; w_data = data;
        step();
        w_en = 1'b0;
    endtask

    // Step until res_valid or the budget runs out; an expired budget is a
    // failed comparison.
    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_valid_timeout"}, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_clr"}, {31'd0, arr_clr}, 32'd0);
        check_feeds(tag, 0, 0, 0, 0, 0, 0);
        check({tag, "_res_data"}, {24'd0, res_data}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; checks = 0; errors = 0;
        reset = 1'b1; w_en = 1'b0; w_sel = 1'b0; w_row = 2'd0; w_col = 2'd0;
        w_data = 8'd0; start = 1'b0; res_ready = 1'b0; arr_out = 8'd0;

        // Skew run with A = 1..9 row-major, B = identity, ready held high.
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 2, 4, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 3, 5, 7, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 6, 8, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, 9, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-on reset.
        step();
        step();
        check_all_zero("por");
        reset = 1'b0;

        // Load operands.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                write_op(1'b0, 2'(r), 2'(c), 8'(r * 3 + c + 1));
                write_op(1'b1, 2'(r), 2'(c), (r == c) ? 8'd1 : 8'd0);
            end
        end

        // Skew pattern and capture latency, table driven.
        n0 = cyc;
        for (int k = 0; k < 12; k++) begin
            start     = tbl[k].start;
            res_ready = tbl[k].ready;
            check($sformatf("skew%0d_busy", k), {31'd0, busy}, {31'd0, tbl[k].busy});
            check($sformatf("skew%0d_clr", k), {31'd0, arr_clr}, {31'd0, tbl[k].clr});
            check_feeds($sformatf("skew%0d", k), tbl[k].a0, tbl[k].a1, tbl[k].a2,
                        tbl[k].b0, tbl[k].b1, tbl[k].b2);
            check($sformatf("skew%0d_valid", k), {31'd0, res_valid},
                  {31'd0, tbl[k].valid});
            if (tbl[k].cap) begin
                check("capture_data", {24'd0, res_data}, {24'd0, 8'(n0 + 9)});
            end
            step();
        end
        start = 1'b0;

        // Backpressure: ready low for 20 cycles, a stray start in between.
        res_ready = 1'b0;
        n0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("bp", 30);
        check("bp_latency", 32'(cyc - n0), 32'd10);
        check("bp_data", {24'd0, res_data}, {24'd0, 8'(n0 + 9)});
        held = res_data;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            check("bp_valid_hold", {31'd0, res_valid}, 32'd1);
            check("bp_data_hold", {24'd0, res_data}, {24'd0, held});
            check("bp_busy_hold", {31'd0, busy}, 32'd1);
            step();
        end
        start = 1'b0;
        res_ready = 1'b1;
        check("bp_valid_at_pulse", {31'd0, res_valid}, 32'd1);
        step();
        res_ready = 1'b0;
        check("bp_valid_after", {31'd0, res_valid}, 32'd0);
        check("bp_busy_after", {31'd0, busy}, 32'd0);
        step();
        check("bp_no_queued_start_busy", {31'd0, busy}, 32'd0);
        check("bp_no_queued_start_clr", {31'd0, arr_clr}, 32'd0);
        step();
        check("bp_still_idle", {31'd0, busy}, 32'd0);

        // Write gating: a write during FEED and out-of-range writes are
        // dropped; a legal IDLE write taken with start is used by that run.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        write_op(1'b0, 2'd1, 2'd0, 8'hAA);
        res_ready = 1'b1;
        wait_valid("wg_run1", 20);
        step();
        check("wg_idle", {31'd0, busy}, 32'd0);
        write_op(1'b0, 2'd3, 2'd0, 8'h66);
        write_op(1'b0, 2'd0, 2'd3, 8'h66);
        write_op(1'b1, 2'd3, 2'd3, 8'h66);
        w_en = 1'b1; w_sel = 1'b0; w_row = 2'd0; w_col = 2'd0; w_data = 8'h55;
        start = 1'b1;
        step();
        w_en = 1'b0;
        start = 1'b0;
        check("wg_clr", {31'd0, arr_clr}, 32'd1);
        step();
        check_feeds("wg_t0", 8'h55, 0, 0, 1, 0, 0);
        step();
        check_feeds("wg_t1", 2, 4, 0, 0, 0, 0);
        step();
        check_feeds("wg_t2", 3, 5, 7, 0, 1, 0);
        step();
        check_feeds("wg_t3", 0, 6, 8, 0, 0, 0);
        step();
        check_feeds("wg_t4", 0, 0, 9, 0, 0, 1);
        wait_valid("wg_run2", 20);
        step();

        // Abort: reset at FEED t=2, then a fresh run feeds zeros.
        res_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_feeds("abort_t2", 3, 5, 7, 0, 1, 0);
        reset = 1'b1;
        step();
        check_all_zero("abort_rst1");
        step();
        check_all_zero("abort_rst2");
        reset = 1'b0;
        res_ready = 1'b1;
        n0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_clr", {31'd0, arr_clr}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd1);
        for (int t = 0; t < 5; t++) begin
            step();
            check_feeds($sformatf("post_t%0d", t), 0, 0, 0, 0, 0, 0);
            check($sformatf("post_t%0d_busy", t), {31'd0, busy}, 32'd1);
        end
        wait_valid("post", 20);
        check("post_latency", 32'(cyc - n0), 32'd10);
        check("post_data", {24'd0, res_data}, {24'd0, 8'(n0 + 9)});
        step();
        check("post_idle", {31'd0, busy}, 32'd0);
        check("post_valid_low", {31'd0, res_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl_3by3.md
# systolic_ctrl_3by3

Sequencer for the 3x3 weight/data systolic array. It holds two 3x3 8-bit operand matrices (A and B) written through a simple write port. On `start` it clears the array, then streams skewed operands into the array's `in_a_*` and `in_b_*` edges. It samples the array's `out` after a fixed latency and presents the result through a valid/ready handshake. It sits between the host register interface and the `systolic_array_3by3` instance.

## Interface
Parameters:
- `CAPTURE_LAT`, default 7: cycles from the first FEED cycle to the cycle in which `arr_out` is sampled. Legal range is 5..15.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `w_en` in 1: operand write strobe. Honoured only in IDLE.
- `w_sel` in 1: 0 selects matrix A, 1 selects matrix B.
- `w_row` in 2: row index, 0..2. Index 3 is ignored (no write).
- `w_col` in 2: column index, 0..2. Index 3 is ignored (no write).
- `w_data` in 8: operand value.
- `start` in 1: start pulse. Honoured only in IDLE.
- `busy` out 1: high whenever the state is not IDLE.
- `arr_clr` out 1: clear to the array's `reset`. High for exactly one cycle in CLEAR.
- `in_a_0`, `in_a_1`, `in_a_2` out 8 each: A-edge feed to the array.
- `in_b_0`, `in_b_1`, `in_b_2` out 8 each: B-edge feed to the array.
- `arr_out` in 8: the array's `out`.
- `res_data` out 8: captured result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.

## Operation
- States are IDLE, CLEAR, FEED, DRAIN and RESULT. All outputs are registered.
- Operand storage:
  - 18 bytes (`A[r][c]`, `B[r][c]`). A write completes the cycle after `w_en`.
  - Storage is retained across runs; only `reset` clears it to 0.
  - `w_en` outside IDLE, or with row/col equal to 3, is dropped silently.
- IDLE: all feed outputs are 0. On `start`, go to CLEAR. If `w_en` and `start` occur in the same cycle, the write lands and the run uses the new value.
- CLEAR (1 cycle): `arr_clr`=1 and feeds are 0. Then go to FEED with t=0.
- FEED (5 cycles, t=0..4):
  - `in_a_i` = A[i][t-i] when 0 ≤ t-i ≤ 2, else 0.
  - `in_b_j` = B[t-j][j] when 0 ≤ t-j ≤ 2, else 0.
  - After t=4, go to DRAIN.
- DRAIN: feeds are 0. A cycle counter runs from the first FEED cycle (counter=0). When the counter equals `CAPTURE_LAT`, latch `arr_out` into `res_data` and go to RESULT.
- RESULT: `res_valid`=1 and `res_data` is held stable. On `res_ready`=1 the handshake completes that cycle and the block returns to IDLE; `res_valid` is 0 the next cycle.
- `start` outside IDLE is ignored; it is neither queued nor treated as an error.
- No arithmetic is done here. Values pass through unmodified at 8 bits.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `arr_clr`=0.
  - all `in_a_*`/`in_b_*`=0.
  - `res_data`=0, `res_valid`=0.
  - operand storage all 0.
- Reset mid-run (any state) aborts the run next cycle with the values above. No result is produced.
- Cycle schedule, with `start` sampled high in cycle N:
  - `busy`=1 and `arr_clr`=1 in N+1.
  - FEED t=0..4 occupies N+2..N+6.
  - `arr_out` is sampled at the end of cycle N+2+`CAPTURE_LAT`.
  - `res_valid`=1 from N+3+`CAPTURE_LAT`.
- With default `CAPTURE_LAT`=7: `res_valid` first rises at N+10, and the minimum start-to-IDLE time is 11 cycles (ready held high).
- `res_ready` while `res_valid`=0 has no effect.
- A new `start` is accepted in the first IDLE cycle after the handshake.

## Test plan
- Reset:
  - Stimulus: assert `reset` for 2 cycles after random activity.
  - Required: all outputs 0, `busy`=0. A run started immediately afterwards feeds all zeros.
- Skew pattern:
  - Stimulus: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, `start`.
  - Required feed values:
    - t=0: a=(1,0,0), b=(1,0,0).
    - t=2: a=(3,5,7), b=(0,1,0).
    - t=4: a=(0,0,9), b=(0,0,1).
    - All feeds are 0 in CLEAR and DRAIN.
- Capture latency:
  - Stimulus: stub `arr_out` = cycle index, `CAPTURE_LAT`=7, `start` at N.
  - Required: `res_data` = value driven at N+9, `res_valid` rises at N+10.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 20 cycles, then pulse it once.
  - Required: `res_valid`=1 and `res_data` stable throughout, `busy`=1. IDLE follows the pulse; a second `start` during the wait is ignored.
- Write gating:
  - Stimulus: `w_en` with A[0][0]=0x55 during FEED; a write with row=3; then a legal write in IDLE.
  - Required: only the IDLE write takes effect; the next run feeds 0x55 at t=0 on `in_a_0`.
- Abort:
  - Stimulus: `reset` at FEED t=2, then `start` again.
  - Required: immediate IDLE with zeroed storage; the second run produces `res_valid` with the standard latency.
